mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_pkg.sv | 22 ++
 rtl/copy_checksum.sv | 26 ++
 rtl/mem_copy_engine.sv | 128 ++++++++++++
 tb/tb_mem_copy_engine.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_pkg.sv
// Shared widths, FSM state encoding and address helper for the memory copy engine.
package mem_copy_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

    // Base plus word index.
    // The sum is 16 bits wide, so addresses wrap from 0xFFFF back to 0x0000.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return base + ADDR_W'(idx);
    endfunction

endpackage

// File: rtl/copy_checksum.sv
// Running checksum of the words read during a copy.
// Instantiated only when COPY_CHECKSUM_EN is defined.
module copy_checksum
    import mem_copy_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    output logic [DATA_W-1:0] sum
);

    // Modulo-2^16 accumulation.
    // Restarted by every accepted copy request; holds its value while the engine idles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + add_data;
        end
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Word-by-word RAM-to-RAM copy engine: read one word, write it, advance, repeat.
// Optional feature: define COPY_CHECKSUM_EN to add the Checksum output and its accumulator.
module mem_copy_engine
    import mem_copy_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] SrcAddress,
    input  logic [ADDR_W-1:0] DstAddress,
    input  logic [CNT_W-1:0]  WordCount,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] DataAddress,
    output logic              ReadMem,
    output logic              WriteMem,
    output logic [DATA_W-1:0] DataIn,
    input  logic [DATA_W-1:0] DataOut
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] Checksum
`endif
);

    copy_state_t       state;
    copy_state_t       next_state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  idx_q;
    logic [DATA_W-1:0] buffer_q;
    logic              accept_start;
    logic              last_word;

    assign accept_start = (state == IDLE) && Start;
    assign last_word    = ((idx_q + CNT_W'(1)) == count_q);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand latch, word index and data buffer.
    // Operands are captured only on an accepted start, so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q    <= '0;
            dst_q    <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            buffer_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        src_q   <= SrcAddress;
                        dst_q   <= DstAddress;
                        count_q <= WordCount;
                        idx_q   <= '0;
                    end
                end
                READ: begin
                    buffer_q <= DataOut;
                end
                WRITE: begin
                    idx_q <= idx_q + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic and RAM port drive.
    // The port is quiet (zero address and data) outside READ and WRITE.
    always_comb begin
        next_state  = state;
        Busy        = 1'b0;
        Done        = 1'b0;
        ReadMem     = 1'b0;
        WriteMem    = 1'b0;
        DataAddress = '0;
        DataIn      = '0;
        case (state)
            IDLE: begin
                if (Start) begin
                    next_state = (WordCount != '0) ? READ : DONE;
                end
            end
            READ: begin
                Busy        = 1'b1;
                ReadMem     = 1'b1;
                DataAddress = word_addr(src_q, idx_q);
                next_state  = WRITE;
            end
            WRITE: begin
                Busy        = 1'b1;
                WriteMem    = 1'b1;
                DataAddress = word_addr(dst_q, idx_q);
                DataIn      = buffer_q;
                next_state  = last_word ? DONE : READ;
            end
            DONE: begin
                Done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef COPY_CHECKSUM_EN
    copy_checksum u_checksum (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept_start),
        .add_en   (state == READ),
        .add_data (DataOut),
        .sum      (Checksum)
    );
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine.
// It uses a behavioural RAM, a table of directed copies and hand-written corner sequences.
// Checksum checks are compiled in when COPY_CHECKSUM_EN is defined.
module tb_mem_copy_engine;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [15:0] SrcAddress;
    logic [15:0] DstAddress;
    logic [8:0]  WordCount;
    logic        Busy;
    logic        Done;
    logic [15:0] DataAddress;
    logic        ReadMem;
    logic        WriteMem;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
`ifdef COPY_CHECKSUM_EN
    logic [15:0] Checksum;
`endif

    logic [15:0] ram   [0:65535];
    logic [15:0] model [0:65535];
    logic        loadEn;
    logic [15:0] loadAddr;
    logic [15:0] loadData;

    int vectors;
    int miscompares;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [8:0]  n;
        logic [15:0] base;
        logic [15:0] step;
        int          latency;
        logic [15:0] sum;
    } vec_t;

    localparam int NUM_VEC = 6;
    vec_t vecs [NUM_VEC];

    mem_copy_engine dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (Start),
        .SrcAddress  (SrcAddress),
        .DstAddress  (DstAddress),
        .WordCount   (WordCount),
        .Busy        (Busy),
        .Done        (Done),
        .DataAddress (DataAddress),
        .ReadMem     (ReadMem),
        .WriteMem    (WriteMem),
        .DataIn      (DataIn),
        .DataOut     (DataOut)
`ifdef COPY_CHECKSUM_EN
        ,
        .Checksum    (Checksum)
`endif
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM.
    // Reads are combinational.
    // Writes happen on the rising edge, from the DUT or from the bench preload port.
    assign DataOut = ReadMem ? ram[DataAddress] : 16'h0000;
    always @(posedge clk) begin
        if (WriteMem) begin
            ram[DataAddress] <= DataIn;
        end else if (loadEn) begin
            ram[loadAddr] <= loadData;
        end
    end

    // Compare one observed value against its expected value.
    // Every comparison is counted; a mismatch prints a FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Write one word into the RAM and the shadow model while the DUT is idle.
    task automatic loadWord(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        loadEn   = 1'b1;
        loadAddr = a;
        loadData = v;
        @(posedge clk);
        #1;
        loadEn   = 1'b0;
        model[a] = v;
    endtask

    // Fill the destination window (plus one word past its end) with 0x5A5A.
    // Then fill the source with base + k*step; the source wins where the two ranges overlap.
    task automatic preloadRegion(input logic [15:0] s, input logic [15:0] d, input logic [8:0] n,
                                 input logic [15:0] base, input logic [15:0] step);
        logic [15:0] v;
        for (int k = 0; k <= int'(n); k++) begin
            loadWord(d + 16'(k), 16'h5A5A);
        end
        v = base;
        for (int k = 0; k < int'(n); k++) begin
            loadWord(s + 16'(k), v);
            v = v + step;
        end
    endtask

    // Issue one start request.
    // The operand inputs are then scrambled, so a DUT that fails to latch them shows up.
    // The task returns 1 ns after the start edge, i.e. in cycle 1.
    task automatic applyStimulus(input logic [15:0] s, input logic [15:0] d, input logic [8:0] n);
        @(negedge clk);
        Start      = 1'b1;
        SrcAddress = s;
        DstAddress = d;
        WordCount  = n;
        @(posedge clk);
        #1;
        Start      = 1'b0;
        SrcAddress = ~s;
        DstAddress = ~d;
        WordCount  = 9'd7;
    endtask

    // Watch the DUT cycle by cycle until Done or until the budget runs out.
    // Tallies Busy, read and write cycles, address errors, read/write overlap and port noise in DONE.
    task automatic runMonitor(input logic [15:0] s, input logic [15:0] d, input int budget,
                              output int lat, output int busyCyc, output int rdCyc, output int wrCyc,
                              output int badAddr, output int overlap, output int doneNoise);
        int cyc;
        cyc = 1;
        lat = -1;
        busyCyc = 0;
        rdCyc = 0;
        wrCyc = 0;
        badAddr = 0;
        overlap = 0;
        doneNoise = 0;
        while (cyc <= budget) begin
            if (ReadMem && WriteMem) overlap++;
            if (Busy) busyCyc++;
            if (ReadMem) begin
                if (DataAddress !== s + 16'(rdCyc)) badAddr++;
                rdCyc++;
            end
            if (WriteMem) begin
                if (DataAddress !== d + 16'(wrCyc)) badAddr++;
                wrCyc++;
            end
            if (Done) begin
                lat = cyc;
                if (DataAddress !== 16'h0000 || DataIn !== 16'h0000 || ReadMem || WriteMem || Busy) doneNoise++;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Main test sequence: reset, table-driven copies, then the multi-cycle corner cases.
    initial begin
        int lat, busyCyc, rdCyc, wrCyc, badAddr, overlap, doneNoise;
        int doneCount, firstDone;
        logic [15:0] s, d;
        logic [8:0]  n;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        Start       = 1'b0;
        SrcAddress  = '0;
        DstAddress  = '0;
        WordCount   = '0;
        loadEn      = 1'b0;
        loadAddr    = '0;
        loadData    = '0;

        vecs[0] = '{16'h0010, 16'h0040, 9'd4,   16'h0001, 16'h0001, 9,   16'h000A};
        vecs[1] = '{16'h0100, 16'h0200, 9'd0,   16'h7777, 16'h0001, 1,   16'h0000};
        vecs[2] = '{16'hFFFF, 16'h0020, 9'd2,   16'hFFFF, 16'h0003, 5,   16'h0001};
        vecs[3] = '{16'h0300, 16'h0400, 9'd1,   16'hABCD, 16'h0000, 3,   16'hABCD};
        vecs[4] = '{16'h0500, 16'h0501, 9'd3,   16'h1000, 16'h0001, 7,   16'h3000};
        vecs[5] = '{16'h8000, 16'h9000, 9'd256, 16'h0000, 16'h0001, 513, 16'h7F80};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset Busy", 32'(Busy), 32'h0);
        checkOutput("reset Done", 32'(Done), 32'h0);
        checkOutput("reset ReadMem", 32'(ReadMem), 32'h0);
        checkOutput("reset WriteMem", 32'(WriteMem), 32'h0);
        checkOutput("reset DataAddress", 32'(DataAddress), 32'h0);
        checkOutput("reset DataIn", 32'(DataIn), 32'h0);
`ifdef COPY_CHECKSUM_EN
        checkOutput("reset Checksum", 32'(Checksum), 32'h0);
`endif

        for (int v = 0; v < NUM_VEC; v++) begin
            s = vecs[v].src;
            d = vecs[v].dst;
            n = vecs[v].n;
            preloadRegion(s, d, n, vecs[v].base, vecs[v].step);
            applyStimulus(s, d, n);
            runMonitor(s, d, 600, lat, busyCyc, rdCyc, wrCyc, badAddr, overlap, doneNoise);
            checkOutput($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].latency));
            checkOutput($sformatf("vec%0d busy cycles", v), 32'(busyCyc), 32'(2 * int'(n)));
            checkOutput($sformatf("vec%0d read cycles", v), 32'(rdCyc), 32'(n));
            checkOutput($sformatf("vec%0d write cycles", v), 32'(wrCyc), 32'(n));
            checkOutput($sformatf("vec%0d address errors", v), 32'(badAddr), 32'h0);
            checkOutput($sformatf("vec%0d rd/wr overlap", v), 32'(overlap), 32'h0);
            checkOutput($sformatf("vec%0d port in DONE", v), 32'(doneNoise), 32'h0);
`ifdef COPY_CHECKSUM_EN
            checkOutput($sformatf("vec%0d checksum at Done", v), 32'(Checksum), 32'(vecs[v].sum));
`endif
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d Done one cycle", v), 32'(Done), 32'h0);
            checkOutput($sformatf("vec%0d Busy after", v), 32'(Busy), 32'h0);
`ifdef COPY_CHECKSUM_EN
            checkOutput($sformatf("vec%0d checksum held", v), 32'(Checksum), 32'(vecs[v].sum));
`endif
            for (int k = 0; k < int'(n); k++) begin
                model[d + 16'(k)] = model[s + 16'(k)];
            end
            for (int k = 0; k <= int'(n); k++) begin
                checkOutput($sformatf("vec%0d word %0d", v, k), 32'(ram[d + 16'(k)]), 32'(model[d + 16'(k)]));
            end
        end

        // Second Start arrives in cycle 3 with different operands and must be ignored.
        preloadRegion(16'h0800, 16'h0900, 9'd4, 16'h3000, 16'h0005);
        loadWord(16'h0B00, 16'h5A5A);
        applyStimulus(16'h0800, 16'h0900, 9'd4);
        doneCount = 0;
        firstDone = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 3) begin
                Start      = 1'b1;
                SrcAddress = 16'h0A00;
                DstAddress = 16'h0B00;
                WordCount  = 9'd2;
            end
            if (cyc == 4) Start = 1'b0;
            if (Done) begin
                doneCount++;
                if (firstDone < 0) firstDone = cyc;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("busy-start Done count", 32'(doneCount), 32'd1);
        checkOutput("busy-start Done cycle", 32'(firstDone), 32'd9);
        checkOutput("busy-start word0", 32'(ram[16'h0900]), 32'h3000);
        checkOutput("busy-start word3", 32'(ram[16'h0903]), 32'h300F);
        checkOutput("busy-start ignored dst", 32'(ram[16'h0B00]), 32'h5A5A);

        // Reset during the third WRITE (cycle 6): three words land, the fourth stays untouched.
        preloadRegion(16'h0600, 16'h0700, 9'd8, 16'h2000, 16'h0001);
        applyStimulus(16'h0600, 16'h0700, 9'd8);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("abort in WRITE", 32'(WriteMem), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort Busy", 32'(Busy), 32'h0);
        checkOutput("abort Done", 32'(Done), 32'h0);
        checkOutput("abort WriteMem", 32'(WriteMem), 32'h0);
`ifdef COPY_CHECKSUM_EN
        checkOutput("abort Checksum", 32'(Checksum), 32'h0);
`endif
        reset = 1'b0;
        doneCount = 0;
        overlap = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (Done) doneCount++;
            if (WriteMem || ReadMem) overlap++;
            @(posedge clk);
            #1;
        end
        checkOutput("abort no Done", 32'(doneCount), 32'h0);
        checkOutput("abort port quiet", 32'(overlap), 32'h0);
        checkOutput("abort word0", 32'(ram[16'h0700]), 32'h2000);
        checkOutput("abort word1", 32'(ram[16'h0701]), 32'h2001);
        checkOutput("abort word2", 32'(ram[16'h0702]), 32'h2002);
        checkOutput("abort word3", 32'(ram[16'h0703]), 32'h5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
